// File: rtl/rfs_wifi_key_debounce.sv
// Debounces active-low push-buttons into clean levels for the key PIO, with a press strobe.
// Optional auto-repeat pulses while a key is held: define KEY_DEBOUNCE_REPEAT_EN.
module rfs_wifi_key_debounce #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] press_pulse
);

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int unsigned MAX_DR    = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_COUNT = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
`else
  localparam int unsigned MAX_COUNT = DEBOUNCE_CYCLES;
  // Repeat timing is accepted for port/parameter compatibility but has no effect here.
  localparam int unsigned unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_PERIOD;
`endif
  localparam int unsigned CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cfg
    $error("DEBOUNCE_CYCLES must be >= 2");
  end

  logic [NUM_KEYS-1:0] s1;
  logic [NUM_KEYS-1:0] s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic [CNT_W-1:0] cnt;
    logic             key_q;
    logic             pulse_q;
    logic             mismatch;
    logic             accept;
    logic             press_acc;

    always_comb begin
      mismatch  = s2[g] ^ key_q;
      accept    = mismatch && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
      press_acc = accept && key_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt   <= '0;
        key_q <= 1'b1;
      end else if (!mismatch) begin
        cnt <= '0;
      end else if (accept) begin
        cnt   <= '0;
        key_q <= s2[g];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    logic [CNT_W-1:0] rcnt;
    logic             rep_hit;

    // A release acceptance in the same cycle as a repeat hit wins: no pulse.
    always_comb begin
      rep_hit = !key_q && !accept && (rcnt == CNT_W'(REPEAT_DELAY - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rcnt    <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= press_acc || rep_hit;
        if (key_q || accept) begin
          rcnt <= '0;
        end else if (rep_hit) begin
          rcnt <= CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
          rcnt <= rcnt + CNT_W'(1);
        end
      end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= press_acc;
      end
    end
`endif

    assign key_out[g]     = key_q;
    assign press_pulse[g] = pulse_q;
  end

endmodule
